// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings, flag bit positions and the
// packed result entry carried through the execute-to-writeback stage.
package alu_pkg;

    localparam int ALU_DW = 16;
    localparam int ALU_RW = 3;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_XOR = 3'b100,
        ALU_NOT = 3'b101,
        ALU_SLA = 3'b110,
        ALU_SRA = 3'b111
    } alucon_t;

    localparam int FLG_N = 2;
    localparam int FLG_Z = 1;
    localparam int FLG_C = 0;

    typedef struct packed {
        logic [ALU_DW-1:0] data;
        logic [ALU_RW-1:0] rd;
        logic              we;
        logic [2:0]        flags;
    } entry_t;

    // State value is literally {head_v, skid_v}
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b10,
        ST_TWO   = 2'b11
    } stage_state_t;

endpackage

// File: rtl/result_flag_gen.sv
// Combinational {N,Z,C} flag derivation from an ALU result; carry only
// survives for arithmetic opcodes, logic/shift ops report C = 0.
module result_flag_gen
    import alu_pkg::*;
#(
    parameter int DW = ALU_DW
) (
    input  logic [DW-1:0] result,
    input  logic          carry,
    input  logic [2:0]    alucon,
    output logic [2:0]    flags
);

    always_comb begin
        flags        = '0;
        flags[FLG_N] = result[DW-1];
        flags[FLG_Z] = (result == '0);
        flags[FLG_C] = ((alucon == ALU_ADD) || (alucon == ALU_SUB)) ? carry : 1'b0;
    end

endmodule

// File: rtl/alu_result_stage.sv
// Execute-to-writeback stage: two-entry skid buffer with valid/ready
// handshake, capture-time flag generation and a committed flag register.
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int DW = ALU_DW,
    parameter int RW = ALU_RW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] ALUOUT,
    input  logic          carry,
    input  logic [2:0]    ALUCON,
    input  logic [RW-1:0] in_rd,
    input  logic          in_we,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [RW-1:0] out_rd,
    output logic          out_we,
    output logic [2:0]    out_flags,
    output logic [2:0]    flag_reg
);

    stage_state_t state;
    entry_t       head;
    entry_t       skid;
    entry_t       incoming;
    logic [2:0]   new_flags;
    logic         head_v;
    logic         skid_v;
    logic         accept;
    logic         transfer;

    result_flag_gen #(.DW(DW)) u_flag_gen (
        .result (ALUOUT),
        .carry  (carry),
        .alucon (ALUCON),
        .flags  (new_flags)
    );

    assign incoming = '{data: ALUOUT, rd: in_rd, we: in_we, flags: new_flags};

    assign head_v   = (state != ST_EMPTY);
    assign skid_v   = (state == ST_TWO);
    assign accept   = in_valid && !skid_v;
    assign transfer = head_v && out_ready;

    // in_ready comes straight from state, so it never sees out_ready
    assign in_ready  = !skid_v;
    assign out_valid = head_v;
    assign out_data  = head.data;
    assign out_rd    = head.rd;
    assign out_we    = head.we;
    assign out_flags = head.flags;

    // Flush still lets the departing head commit its flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_EMPTY;
            head     <= '0;
            skid     <= '0;
            flag_reg <= '0;
        end else begin
            if (transfer && head.we) begin
                flag_reg <= head.flags;
            end
            if (flush) begin
                state <= ST_EMPTY;
            end else begin
                case (state)
                    ST_EMPTY: begin
                        if (accept) begin
                            head  <= incoming;
                            state <= ST_ONE;
                        end
                    end
                    ST_ONE: begin
                        if (accept && transfer) begin
                            head <= incoming;
                        end else if (accept) begin
                            skid  <= incoming;
                            state <= ST_TWO;
                        end else if (transfer) begin
                            state <= ST_EMPTY;
                        end
                    end
                    ST_TWO: begin
                        if (transfer) begin
                            head  <= skid;
                            state <= ST_ONE;
                        end
                    end
                    default: state <= ST_EMPTY;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_alu_result_stage.sv
// Self-checking bench for alu_result_stage: directed scenarios plus random
// traffic compared against a queue-based FIFO model of the stage.
module tb_alu_result_stage;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] aluout;
    logic        carry;
    logic [2:0]  alucon;
    logic [2:0]  in_rd;
    logic        in_we;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [2:0]  out_rd;
    logic        out_we;
    logic [2:0]  out_flags;
    logic [2:0]  flag_reg;

    typedef struct {
        logic [15:0] data;
        logic [2:0]  rd;
        logic        we;
        logic [2:0]  flags;
    } exp_t;

    exp_t       model_q[$];
    logic [2:0] model_flag_reg;
    int         check_count;
    int         pass_count;

    alu_result_stage #(.DW(16), .RW(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ALUOUT    (aluout),
        .carry     (carry),
        .ALUCON    (alucon),
        .in_rd     (in_rd),
        .in_we     (in_we),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_rd    (out_rd),
        .out_we    (out_we),
        .out_flags (out_flags),
        .flag_reg  (flag_reg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Flags from the architectural rules: N is the sign bit, Z is all-zero,
    // C only passes through for add and subtract
    function automatic logic [2:0] expected_flags(input logic [15:0] d, input logic c,
                                                  input logic [2:0] op);
        logic n;
        logic z;
        logic cf;
        n  = (d >= 16'h8000);
        z  = (d == 16'd0);
        cf = (op == 3'd0 || op == 3'd1) ? c : 1'b0;
        return {n, z, cf};
    endfunction

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        check_count++;
        assert (observed === expected) pass_count++;
        else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    endtask

    task automatic checkOutput();
        check("out_valid", {31'd0, out_valid}, {31'd0, model_q.size() > 0});
        check("in_ready", {31'd0, in_ready}, {31'd0, model_q.size() < 2});
        check("flag_reg", {29'd0, flag_reg}, {29'd0, model_flag_reg});
        if (model_q.size() > 0) begin
            check("out_data", {16'd0, out_data}, {16'd0, model_q[0].data});
            check("out_rd", {29'd0, out_rd}, {29'd0, model_q[0].rd});
            check("out_we", {31'd0, out_we}, {31'd0, model_q[0].we});
            check("out_flags", {29'd0, out_flags}, {29'd0, model_q[0].flags});
        end
    endtask

    // One clock: check at the falling edge, advance the model with the
    // handshake the DUT will see at the next rising edge
    task automatic cycle();
        logic acc;
        logic xfer;
        exp_t e;
        @(negedge clk);
        checkOutput();
        acc  = in_valid && (model_q.size() < 2);
        xfer = (model_q.size() > 0) && out_ready;
        if (xfer) begin
            if (model_q[0].we) model_flag_reg = model_q[0].flags;
            void'(model_q.pop_front());
        end
        if (flush) begin
            model_q.delete();
        end else if (acc) begin
            e.data  = aluout;
            e.rd    = in_rd;
            e.we    = in_we;
            e.flags = expected_flags(aluout, carry, alucon);
            model_q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [15:0] d, input logic c,
                                 input logic [2:0] op, input logic [2:0] rd, input logic we,
                                 input logic ordy, input logic fl);
        in_valid  = v;
        aluout    = d;
        carry     = c;
        alucon    = op;
        in_rd     = rd;
        in_we     = we;
        out_ready = ordy;
        flush     = fl;
        cycle();
    endtask

    initial begin
        check_count    = 0;
        pass_count     = 0;
        model_flag_reg = 3'b000;
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        aluout    = 16'd0;
        carry     = 1'b0;
        alucon    = 3'd0;
        in_rd     = 3'd0;
        in_we     = 1'b0;
        out_ready = 1'b0;

        // Reset values while held in reset
        #13;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_data", {16'd0, out_data}, 32'd0);
        check("rst_out_rd", {29'd0, out_rd}, 32'd0);
        check("rst_out_we", {31'd0, out_we}, 32'd0);
        check("rst_out_flags", {29'd0, out_flags}, 32'd0);
        check("rst_flag_reg", {29'd0, flag_reg}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        applyStimulus(0, 16'h0, 0, 3'd0, 3'd0, 0, 1, 0);

        // Basic: ADD of zero with carry
        applyStimulus(1, 16'h0000, 1, 3'b000, 3'd3, 1, 1, 0);
        check("basic_flags", {29'd0, out_flags}, 32'b011);
        applyStimulus(0, 16'h0, 0, 3'd0, 3'd0, 0, 1, 0);
        check("basic_flag_reg", {29'd0, flag_reg}, 32'b011);

        // Carry masking on XOR
        applyStimulus(1, 16'h8001, 1, 3'b100, 3'd5, 1, 0, 0);
        check("mask_flags", {29'd0, out_flags}, 32'b100);
        applyStimulus(0, 16'h0, 0, 3'd0, 3'd0, 0, 1, 0);
        applyStimulus(0, 16'h0, 0, 3'd0, 3'd0, 0, 1, 0);

        // Backpressure: A, B, C with out_ready low, then drain
        applyStimulus(1, 16'h00A1, 0, 3'b010, 3'd1, 1, 0, 0);
        applyStimulus(1, 16'h00B2, 1, 3'b001, 3'd2, 1, 0, 0);
        applyStimulus(1, 16'h00C3, 1, 3'b000, 3'd4, 0, 0, 0);
        check("bp_stall", {31'd0, in_ready}, 32'd0);
        applyStimulus(1, 16'h00C3, 1, 3'b000, 3'd4, 0, 1, 0);
        applyStimulus(1, 16'h00C3, 1, 3'b000, 3'd4, 0, 1, 0);
        applyStimulus(0, 16'h0, 0, 3'd0, 3'd0, 0, 1, 0);
        applyStimulus(0, 16'h0, 0, 3'd0, 3'd0, 0, 1, 0);
        applyStimulus(0, 16'h0, 0, 3'd0, 3'd0, 0, 1, 0);

        // Simultaneous accept and transfer stream
        for (int i = 0; i < 11; i++) begin
            applyStimulus(1, 16'(i * 16'h1111 + 16'h0F0F), 1'(i), 3'(i), 3'(i), 1, 1, 0);
        end
        applyStimulus(0, 16'h0, 0, 3'd0, 3'd0, 0, 1, 0);

        // Flush in TWO with incoming entry and transfer
        applyStimulus(1, 16'h8000, 1, 3'b001, 3'd6, 1, 0, 0);
        applyStimulus(1, 16'h1234, 0, 3'b011, 3'd7, 1, 0, 0);
        applyStimulus(1, 16'h0000, 1, 3'b000, 3'd2, 1, 1, 1);
        check("flush_flag_reg", {29'd0, flag_reg}, 32'b101);
        applyStimulus(0, 16'h0, 0, 3'd0, 3'd0, 0, 1, 0);

        // Async reset while in TWO with nonzero flag_reg
        applyStimulus(1, 16'hFFFE, 1, 3'b000, 3'd1, 1, 1, 0);
        applyStimulus(1, 16'h4321, 0, 3'b010, 3'd2, 1, 0, 0);
        applyStimulus(1, 16'h5555, 0, 3'b011, 3'd3, 0, 0, 0);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", {31'd0, out_valid}, 32'd0);
        check("arst_flag_reg", {29'd0, flag_reg}, 32'd0);
        check("arst_in_ready", {31'd0, in_ready}, 32'd1);
        check("arst_out_data", {16'd0, out_data}, 32'd0);
        model_q.delete();
        model_flag_reg = 3'b000;
        rst_n = 1'b1;
        applyStimulus(0, 16'h0, 0, 3'd0, 3'd0, 0, 1, 0);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            logic [15:0] d;
            d = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom);
            applyStimulus($urandom_range(0, 9) < 7, d, 1'($urandom), 3'($urandom),
                          3'($urandom), 1'($urandom), $urandom_range(0, 9) < 6,
                          $urandom_range(0, 19) == 0);
        end
        applyStimulus(0, 16'h0, 0, 3'd0, 3'd0, 0, 1, 0);
        applyStimulus(0, 16'h0, 0, 3'd0, 3'd0, 0, 1, 0);
        applyStimulus(0, 16'h0, 0, 3'd0, 3'd0, 0, 1, 0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
